// File: rtl/haraka_absorb_ctrl.sv
// Haraka sponge absorb front end: packs INWIDTH-bit words into RATE-bit blocks and applies 0x1F/bit-(RATE-1) padding.
// Latency: one cycle from the completing word to blk_valid. Backpressure: block held and in_ready low until blk_ready.
module haraka_absorb_ctrl #(
  parameter int INWIDTH = 64,
  parameter int RATE    = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [INWIDTH-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [RATE-1:0]    blk_data,
  output logic               blk_valid,
  output logic               blk_last,
  input  logic               blk_ready,
  output logic [15:0]        blk_count
);

  localparam int WORDS = RATE / INWIDTH;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]      LAST_CNT = CW'(WORDS - 1);
  localparam logic [INWIDTH-1:0] PAD_WORD = {{(INWIDTH-5){1'b0}}, 5'h1F};
  localparam logic [RATE-1:0]    PAD_BLK  = {1'b1, {(RATE-INWIDTH-1){1'b0}}, PAD_WORD};

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            pad_pending;
  logic [RATE-1:0] fill_blk;
  logic            accept;
  logic            last_slot;

  assign accept    = in_valid && in_ready;
  assign last_slot = (cnt == LAST_CNT);
  assign cnt_nxt   = cnt + 1'b1;

  // A short final word gets its padding folded into the same block.
  always_comb begin
    fill_blk = blk_data;
    fill_blk[cnt*INWIDTH +: INWIDTH] = in_data;
    if (in_last && !last_slot) begin
      for (int k = 0; k < WORDS; k++) begin
        if (CW'(k) > cnt) begin
          fill_blk[k*INWIDTH +: INWIDTH] = '0;
        end
      end
      fill_blk[cnt_nxt*INWIDTH +: INWIDTH] = PAD_WORD;
      fill_blk[RATE-1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      cnt         <= '0;
      pad_pending <= 1'b0;
      blk_data    <= '0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      blk_count   <= '0;
      in_ready    <= 1'b0;
    end else if (clear) begin
      state       <= FILL;
      cnt         <= '0;
      pad_pending <= 1'b0;
      blk_data    <= '0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      blk_count   <= '0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            blk_data <= fill_blk;
            if (in_last || last_slot) begin
              state       <= EMIT;
              blk_valid   <= 1'b1;
              in_ready    <= 1'b0;
              cnt         <= '0;
              blk_last    <= in_last && !last_slot;
              // A full final block still owes a separate padding-only block.
              pad_pending <= in_last && last_slot;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            blk_count <= blk_count + 16'd1;
            if (pad_pending) begin
              state    <= EMIT_PAD;
              blk_data <= PAD_BLK;
              blk_last <= 1'b1;
            end else begin
              state     <= FILL;
              blk_data  <= '0;
              blk_valid <= 1'b0;
              blk_last  <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        EMIT_PAD: begin
          if (blk_ready) begin
            blk_count   <= blk_count + 16'd1;
            pad_pending <= 1'b0;
            state       <= FILL;
            blk_data    <= '0;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          state     <= FILL;
          blk_valid <= 1'b0;
          blk_last  <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haraka_absorb_ctrl.sv
// Directed bench for haraka_absorb_ctrl: vector table of whole messages plus stall, reset and clear sequences.
module tb_haraka_absorb_ctrl;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [255:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;
  logic [15:0]  blk_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  localparam logic [255:0] PAD_BLK = {1'b1, 191'b0, 64'h1F};

  haraka_absorb_ctrl #(.INWIDTH(64), .RATE(256)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(blk_ready), .blk_count(blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int           n;
    logic [255:0] w;
    logic         last;
    logic [255:0] exp_data;
    logic         exp_last;
    logic         exp_pad;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b1;

    vecs[0] = '{4, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b1,
                {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, 1'b1};
    vecs[1] = '{1, {192'd0, 64'hA5}, 1'b1,
                {64'h8000000000000000, 64'h0, 64'h1F, 64'hA5}, 1'b1, 1'b0};
    vecs[2] = '{3, {64'h0, 64'h33, 64'h22, 64'h11}, 1'b1,
                {64'h800000000000001F, 64'h33, 64'h22, 64'h11}, 1'b1, 1'b0};
    vecs[3] = '{4, {64'hDEADBEEF00000004, 64'hDEADBEEF00000003, 64'hDEADBEEF00000002, 64'hDEADBEEF00000001}, 1'b0,
                {64'hDEADBEEF00000004, 64'hDEADBEEF00000003, 64'hDEADBEEF00000002, 64'hDEADBEEF00000001}, 1'b0, 1'b0};
    vecs[4] = '{2, {128'd0, 64'hBBBB, 64'hAAAA}, 1'b1,
                {64'h8000000000000000, 64'h1F, 64'hBBBB, 64'hAAAA}, 1'b1, 1'b0};
    vecs[5] = '{1, {192'd0, 64'hFFFFFFFFFFFFFFFF}, 1'b1,
                {64'h8000000000000000, 64'h0, 64'h1F, 64'hFFFFFFFFFFFFFFFF}, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_blk_data", blk_data, 0);
    check("rst_blk_count", blk_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_blk_valid", blk_valid, 0);

    // Table of whole messages with blk_ready held high
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        send_word(vecs[i].w[k*64 +: 64], vecs[i].last && (k == vecs[i].n - 1));
      check($sformatf("v%0d_blk_valid", i), blk_valid, 1);
      check($sformatf("v%0d_blk_data", i), blk_data, vecs[i].exp_data);
      check($sformatf("v%0d_blk_last", i), blk_last, vecs[i].exp_last);
      check($sformatf("v%0d_in_ready_emit", i), in_ready, 0);
      check($sformatf("v%0d_count_pre", i), blk_count, 16'(exp_count));
      exp_count++;
      @(negedge clk);
      if (vecs[i].exp_pad) begin
        check($sformatf("v%0d_pad_valid", i), blk_valid, 1);
        check($sformatf("v%0d_pad_data", i), blk_data, PAD_BLK);
        check($sformatf("v%0d_pad_last", i), blk_last, 1);
        exp_count++;
        @(negedge clk);
      end
      check($sformatf("v%0d_fill_valid", i), blk_valid, 0);
      check($sformatf("v%0d_fill_in_ready", i), in_ready, 1);
      check($sformatf("v%0d_count", i), blk_count, 16'(exp_count));
    end

    // Backpressure: block held for 5 cycles, extra word offered but must be ignored
    blk_ready = 1'b0;
    send_word(64'h10, 1'b0); send_word(64'h11, 1'b0); send_word(64'h12, 1'b0); send_word(64'h13, 1'b0);
    in_valid = 1'b1; in_data = 64'h99;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", blk_valid, 1);
      check("stall_data", blk_data, {64'h13, 64'h12, 64'h11, 64'h10});
      check("stall_in_ready", in_ready, 0);
      check("stall_count", blk_count, 16'(exp_count));
      @(negedge clk);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_count++;
    check("stall_hs_count", blk_count, 16'(exp_count));
    check("stall_hs_valid", blk_valid, 0);
    check("stall_hs_in_ready", in_ready, 1);

    // Reset mid-block discards partial data
    send_word(64'hEE, 1'b0); send_word(64'hFF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_count", blk_count, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    exp_count = 0;
    send_word(64'h21, 1'b0); send_word(64'h22, 1'b0); send_word(64'h23, 1'b0); send_word(64'h24, 1'b0);
    check("midrst_blk_data", blk_data, {64'h24, 64'h23, 64'h22, 64'h21});
    check("midrst_blk_last", blk_last, 0);
    @(negedge clk);
    check("midrst_blk_count", blk_count, 1);

    // Clear in EMIT overrides a simultaneous handshake
    blk_ready = 1'b0;
    send_word(64'h31, 1'b0); send_word(64'h32, 1'b0); send_word(64'h33, 1'b0); send_word(64'h34, 1'b1);
    check("clr_pre_valid", blk_valid, 1);
    clear = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_blk_valid", blk_valid, 0);
    check("clr_blk_count", blk_count, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_blk_data", blk_data, 0);
    send_word(64'h5, 1'b1);
    check("clr_new_data", blk_data, {64'h8000000000000000, 64'h0, 64'h1F, 64'h5});
    check("clr_new_last", blk_last, 1);
    @(negedge clk);
    check("clr_new_count", blk_count, 1);
    check("clr_no_pad", blk_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
